// File: rtl/clock_div_meter_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_meter_pkg
// Shared definitions for the divided-clock period/high-time meter:
//   - FSM state encoding (IDLE / MEASURE / LOCKED)
//   - counter width (period/high counters, 5 bits) and match-counter width
//   - saturating increment helper for the 5-bit counters
// -----------------------------------------------------------------------------
package clock_div_meter_pkg;

   localparam int CNT_W   = 5;
   localparam int MATCH_W = 4;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // State encoding kept as plain constants so older tools and netlists that
   // expect a raw 2-bit vector stay compatible.
   localparam logic [1:0] ST_IDLE    = 2'd0;  // waiting for the first rise
   localparam logic [1:0] ST_MEASURE = 2'd1;  // measuring, not yet stable
   localparam logic [1:0] ST_LOCKED  = 2'd2;  // period stable

   // Increment that sticks at the counter maximum instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/clock_div_meter_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings the measured clock into the i_clk domain and detects its edges.
//   i_clk     : sampling clock
//   i_rst     : asynchronous active-low reset (clears all flops)
//   i_div_clk : divided clock under measurement
//   o_sync    : synchronized level (after SYNC_STAGES flops; the raw input
//               when SYNC_STAGES is 0)
//   o_rise    : o_sync high while the history flop is still low
//   o_fall    : o_sync low while the history flop is still high
// -----------------------------------------------------------------------------
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_div_clk,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic hist_reg;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         // Input is already launched from i_clk; no synchronizer needed.
         assign o_sync = i_div_clk;
      end else if (SYNC_STAGES == 1) begin : g_single
         logic stage_reg;
         always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
               stage_reg <= 1'b0;
            end else begin
               stage_reg <= i_div_clk;
            end
         end
         assign o_sync = stage_reg;
      end else begin : g_chain
         logic [SYNC_STAGES-1:0] stage_reg;
         always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
               stage_reg <= '0;
            end else begin
               stage_reg <= {stage_reg[SYNC_STAGES-2:0], i_div_clk};
            end
         end
         assign o_sync = stage_reg[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         hist_reg <= 1'b0;
      end else begin
         hist_reg <= o_sync;
      end
   end

   assign o_rise = o_sync & ~hist_reg;
   assign o_fall = ~o_sync & hist_reg;

endmodule

// File: rtl/clock_div_meter.sv
// -----------------------------------------------------------------------------
// clock_div_meter
// Measures period and high time of a divided clock in i_clk cycles and reports
// when the period has been stable for LOCK_COUNT consecutive measurements.
//   i_clk     : sole clock
//   i_rst     : asynchronous active-low reset
//   i_div_clk : divided clock under measurement
//   o_rise    : one-cycle pulse per detected rising edge of i_div_clk
//   o_period  : last measured period (rising edge to rising edge)
//   o_high    : last measured high time
//   o_valid   : one-cycle pulse when o_period/o_high report a new measurement
//   o_locked  : level, high while in the LOCKED state
//   o_timeout : level, no rising edge within TIMEOUT cycles; cleared by a rise
// -----------------------------------------------------------------------------
module clock_div_meter
   import clock_div_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 31
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_div_clk,
   output logic             o_rise,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam logic [MATCH_W-1:0] LOCK_LIM    = MATCH_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]   TIMEOUT_LIM = CNT_W'(TIMEOUT);

   logic sync_level;
   logic rise;
   logic fall;

   logic [1:0]         state_reg,      state_next;
   logic [CNT_W-1:0]   period_cnt_reg, period_cnt_next;
   logic [CNT_W-1:0]   high_cnt_reg,   high_cnt_next;
   logic [CNT_W-1:0]   period_reg,     period_next;
   logic [CNT_W-1:0]   high_reg,       high_next;
   logic [MATCH_W-1:0] match_reg,      match_next;
   logic [MATCH_W-1:0] match_inc;
   logic               rise_reg;
   logic               valid_reg,      valid_next;
   logic               timeout_reg,    timeout_next;
   logic               fall_seen_reg,  fall_seen_next;

   sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_div_clk(i_div_clk),
      .o_sync   (sync_level),
      .o_rise   (rise),
      .o_fall   (fall)
   );

   always_comb begin
      state_next      = state_reg;
      period_cnt_next = sat_inc(period_cnt_reg);
      high_cnt_next   = sync_level ? sat_inc(high_cnt_reg) : high_cnt_reg;
      period_next     = period_reg;
      high_next       = high_reg;
      match_next      = match_reg;
      valid_next      = 1'b0;
      timeout_next    = timeout_reg;
      fall_seen_next  = fall_seen_reg;
      match_inc       = (match_reg >= LOCK_LIM) ? match_reg : match_reg + 1'b1;

      // High time is captured at the falling edge; in IDLE the last reported
      // value is held untouched.
      if (fall && (state_reg != ST_IDLE)) begin
         high_next      = high_cnt_reg;
         fall_seen_next = 1'b1;
      end

      if (rise) begin
         // The counters restart at 1 so that the value present when the next
         // rise arrives equals the period in i_clk cycles.
         period_cnt_next = 5'd1;
         high_cnt_next   = 5'd1;
         fall_seen_next  = 1'b0;
         timeout_next    = 1'b0;
         if (state_reg == ST_IDLE) begin
            state_next = ST_MEASURE;
         end else begin
            valid_next  = 1'b1;
            period_next = period_cnt_reg;
            // A rise with no fall since the previous one means the level never
            // dropped as seen by us; report the whole period as high time.
            if (!fall_seen_reg) begin
               high_next = period_cnt_reg;
            end
            if (period_cnt_reg == period_reg) begin
               match_next = match_inc;
               state_next = (match_inc == LOCK_LIM) ? ST_LOCKED : ST_MEASURE;
            end else begin
               match_next = '0;
               state_next = ST_MEASURE;
            end
         end
      end else if ((state_reg != ST_IDLE) && (period_cnt_reg >= TIMEOUT_LIM)) begin
         // Rise takes priority above; only a quiet cycle can time out.
         state_next   = ST_IDLE;
         timeout_next = 1'b1;
         match_next   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_reg      <= ST_IDLE;
         period_cnt_reg <= '0;
         high_cnt_reg   <= '0;
         period_reg     <= '0;
         high_reg       <= '0;
         match_reg      <= '0;
         rise_reg       <= 1'b0;
         valid_reg      <= 1'b0;
         timeout_reg    <= 1'b0;
         fall_seen_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         period_cnt_reg <= period_cnt_next;
         high_cnt_reg   <= high_cnt_next;
         period_reg     <= period_next;
         high_reg       <= high_next;
         match_reg      <= match_next;
         rise_reg       <= rise;
         valid_reg      <= valid_next;
         timeout_reg    <= timeout_next;
         fall_seen_reg  <= fall_seen_next;
      end
   end

   assign o_rise    = rise_reg;
   assign o_period  = period_reg;
   assign o_high    = high_reg;
   assign o_valid   = valid_reg;
   assign o_locked  = (state_reg == ST_LOCKED);
   assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_clock_div_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_div_meter
// Directed bench for clock_div_meter. dut_a uses the default parameters,
// dut_b is identical but with no synchronizer stages; both see the same input.
// -----------------------------------------------------------------------------
module tb_clock_div_meter;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       div_clk = 1'b0;

   logic       rise_a, valid_a, locked_a, timeout_a;
   logic [4:0] period_a, high_a;
   logic       rise_b, valid_b, locked_b, timeout_b;
   logic [4:0] period_b, high_b;

   int checks = 0;
   int bad    = 0;
   int cyc    = 0;

   // Event logs filled by the monitor below.
   int rise_a_q[$];
   int rise_b_q[$];
   int vcyc_a_q[$];
   int vper_a_q[$];
   int vhigh_a_q[$];
   int vlock_a_q[$];
   int vper_b_q[$];
   int vhigh_b_q[$];
   bit to_seen_a = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   clock_div_meter #(
      .SYNC_STAGES(2),
      .LOCK_COUNT (4),
      .TIMEOUT    (31)
   ) dut_a (
      .i_clk    (clk),
      .i_rst    (rst_n),
      .i_div_clk(div_clk),
      .o_rise   (rise_a),
      .o_period (period_a),
      .o_high   (high_a),
      .o_valid  (valid_a),
      .o_locked (locked_a),
      .o_timeout(timeout_a)
   );

   clock_div_meter #(
      .SYNC_STAGES(0),
      .LOCK_COUNT (4),
      .TIMEOUT    (31)
   ) dut_b (
      .i_clk    (clk),
      .i_rst    (rst_n),
      .i_div_clk(div_clk),
      .o_rise   (rise_b),
      .o_period (period_b),
      .o_high   (high_b),
      .o_valid  (valid_b),
      .o_locked (locked_b),
      .o_timeout(timeout_b)
   );

   always @(negedge clk) begin
      if (rise_a) rise_a_q.push_back(cyc);
      if (rise_b) rise_b_q.push_back(cyc);
      if (timeout_a) to_seen_a = 1'b1;
      if (valid_a) begin
         vcyc_a_q.push_back(cyc);
         vper_a_q.push_back(int'(period_a));
         vhigh_a_q.push_back(int'(high_a));
         vlock_a_q.push_back(int'(locked_a));
         $display("valid cyc=%0d period=%0d high=%0d locked=%0b", cyc, period_a, high_a, locked_a);
      end
      if (valid_b) begin
         vper_b_q.push_back(int'(period_b));
         vhigh_b_q.push_back(int'(high_b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      rise_a_q.delete();
      rise_b_q.delete();
      vcyc_a_q.delete();
      vper_a_q.delete();
      vhigh_a_q.delete();
      vlock_a_q.delete();
      vper_b_q.delete();
      vhigh_b_q.delete();
      to_seen_a = 1'b0;
   endtask

   task automatic drive_period(input int lo, input int hi);
      div_clk = 1'b0;
      repeat (lo) tick();
      div_clk = 1'b1;
      repeat (hi) tick();
   endtask

   task automatic tail();
      div_clk = 1'b0;
      repeat (5) tick();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      div_clk = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      clear_queues();
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      div_clk = 1'b0;
      repeat (2) tick();
      checks++; if (rise_a !== 1'b0)    begin bad++; $display("FAIL reset_rise got=%0b want=0", rise_a); end
      checks++; if (period_a !== 5'd0)  begin bad++; $display("FAIL reset_period got=%0d want=0", period_a); end
      checks++; if (high_a !== 5'd0)    begin bad++; $display("FAIL reset_high got=%0d want=0", high_a); end
      checks++; if (valid_a !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%0b want=0", valid_a); end
      checks++; if (locked_a !== 1'b0)  begin bad++; $display("FAIL reset_locked got=%0b want=0", locked_a); end
      checks++; if (timeout_a !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", timeout_a); end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({rise_a, valid_a, locked_a, timeout_a, period_a, high_a} !== 14'd0) begin
         bad++;
         $display("FAIL reset_release got=%b want=0", {rise_a, valid_a, locked_a, timeout_a, period_a, high_a});
      end
      clear_queues();
   endtask

   // Divider 6 (3 low, 3 high): every report 6/3, lock on the 5th report.
   task automatic test_div6();
      int c0;
      int got;
      do_reset();
      c0 = cyc;
      repeat (8) drive_period(3, 3);
      tail();
      got = (rise_a_q.size() > 0) ? rise_a_q[0] : -1;
      checks++; if (got !== c0 + 6) begin bad++; $display("FAIL div6_first_rise_a got=%0d want=%0d", got, c0 + 6); end
      got = (rise_b_q.size() > 0) ? rise_b_q[0] : -1;
      checks++; if (got !== c0 + 4) begin bad++; $display("FAIL div6_first_rise_b got=%0d want=%0d", got, c0 + 4); end
      checks++; if (vper_a_q.size() !== 7) begin bad++; $display("FAIL div6_valid_count got=%0d want=7", vper_a_q.size()); end
      for (int k = 0; k < 7; k++) begin
         got = (k < vper_a_q.size()) ? vper_a_q[k] : -1;
         checks++; if (got !== 6) begin bad++; $display("FAIL div6_period[%0d] got=%0d want=6", k, got); end
         got = (k < vhigh_a_q.size()) ? vhigh_a_q[k] : -1;
         checks++; if (got !== 3) begin bad++; $display("FAIL div6_high[%0d] got=%0d want=3", k, got); end
         got = (k < vlock_a_q.size()) ? vlock_a_q[k] : -1;
         checks++; if (got !== ((k >= 4) ? 1 : 0)) begin bad++; $display("FAIL div6_locked[%0d] got=%0d want=%0d", k, got, (k >= 4) ? 1 : 0); end
      end
   endtask

   // Divider 5 (2 low, 3 high), then divider 7 (4 low, 3 high) while locked.
   task automatic test_div5_to_7();
      int got;
      int want_p;
      int want_l;
      do_reset();
      repeat (7) drive_period(2, 3);
      repeat (6) drive_period(4, 3);
      tail();
      checks++; if (vper_a_q.size() !== 12) begin bad++; $display("FAIL div57_valid_count got=%0d want=12", vper_a_q.size()); end
      for (int k = 0; k < 12; k++) begin
         want_p = (k < 6) ? 5 : 7;
         want_l = (k == 4 || k == 5 || k >= 10) ? 1 : 0;
         got = (k < vper_a_q.size()) ? vper_a_q[k] : -1;
         checks++; if (got !== want_p) begin bad++; $display("FAIL div57_period[%0d] got=%0d want=%0d", k, got, want_p); end
         got = (k < vhigh_a_q.size()) ? vhigh_a_q[k] : -1;
         checks++; if (got !== 3) begin bad++; $display("FAIL div57_high[%0d] got=%0d want=3", k, got); end
         got = (k < vlock_a_q.size()) ? vlock_a_q[k] : -1;
         checks++; if (got !== want_l) begin bad++; $display("FAIL div57_locked[%0d] got=%0d want=%0d", k, got, want_l); end
      end
   endtask

   // Stop the clock after locking: timeout exactly 31 cycles after last rise.
   task automatic test_timeout();
      int got;
      int last_rise;
      bit prev_locked;
      bit prev_to;
      bit found;
      do_reset();
      repeat (6) drive_period(3, 3);
      div_clk = 1'b0;
      tick();
      checks++; if (locked_a !== 1'b1) begin bad++; $display("FAIL to_prelocked got=%0b want=1", locked_a); end
      last_rise   = (rise_a_q.size() > 0) ? rise_a_q[rise_a_q.size()-1] : -1;
      prev_locked = locked_a;
      found       = 1'b0;
      for (int n = 0; n < 60; n++) begin
         tick();
         if (timeout_a) begin
            found = 1'b1;
            break;
         end
         prev_locked = locked_a;
      end
      checks++; if (found !== 1'b1) begin bad++; $display("FAIL to_seen got=%0b want=1", found); end
      got = cyc - last_rise;
      checks++; if (got !== 31) begin bad++; $display("FAIL to_latency got=%0d want=31", got); end
      checks++; if (prev_locked !== 1'b1) begin bad++; $display("FAIL to_locked_before got=%0b want=1", prev_locked); end
      checks++; if (locked_a !== 1'b0) begin bad++; $display("FAIL to_locked got=%0b want=0", locked_a); end
      checks++; if (period_a !== 5'd6) begin bad++; $display("FAIL to_period_kept got=%0d want=6", period_a); end
      checks++; if (high_a !== 5'd3) begin bad++; $display("FAIL to_high_kept got=%0d want=3", high_a); end
      div_clk = 1'b1;
      found   = 1'b0;
      prev_to = timeout_a;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (rise_a) begin
            found = 1'b1;
            break;
         end
         prev_to = timeout_a;
      end
      checks++; if (found !== 1'b1) begin bad++; $display("FAIL to_next_rise got=%0b want=1", found); end
      checks++; if (prev_to !== 1'b1) begin bad++; $display("FAIL to_held got=%0b want=1", prev_to); end
      checks++; if (timeout_a !== 1'b0) begin bad++; $display("FAIL to_cleared got=%0b want=0", timeout_a); end
      checks++; if (valid_a !== 1'b0) begin bad++; $display("FAIL to_first_rise_valid got=%0b want=0", valid_a); end
      tail();
   endtask

   // A period of exactly 31 cycles: the rise wins over the timeout.
   task automatic test_boundary31();
      int got;
      do_reset();
      drive_period(3, 3);
      drive_period(28, 3);
      drive_period(4, 3);
      tail();
      checks++; if (vper_a_q.size() !== 2) begin bad++; $display("FAIL b31_valid_count got=%0d want=2", vper_a_q.size()); end
      got = (vper_a_q.size() > 0) ? vper_a_q[0] : -1;
      checks++; if (got !== 31) begin bad++; $display("FAIL b31_period0 got=%0d want=31", got); end
      got = (vper_a_q.size() > 1) ? vper_a_q[1] : -1;
      checks++; if (got !== 7) begin bad++; $display("FAIL b31_period1 got=%0d want=7", got); end
      checks++; if (to_seen_a !== 1'b0) begin bad++; $display("FAIL b31_no_timeout got=%0b want=0", to_seen_a); end
   endtask

   // Asynchronous reset in the middle of a divider-9 period.
   task automatic test_reset_mid();
      int got;
      int want;
      do_reset();
      repeat (6) drive_period(5, 4);
      div_clk = 1'b0;
      repeat (2) tick();
      checks++; if (locked_a !== 1'b1) begin bad++; $display("FAIL rm_prelocked got=%0b want=1", locked_a); end
      checks++; if (period_a !== 5'd9) begin bad++; $display("FAIL rm_preperiod got=%0d want=9", period_a); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (period_a !== 5'd0)  begin bad++; $display("FAIL rm_period got=%0d want=0", period_a); end
      checks++; if (high_a !== 5'd0)    begin bad++; $display("FAIL rm_high got=%0d want=0", high_a); end
      checks++; if (locked_a !== 1'b0)  begin bad++; $display("FAIL rm_locked got=%0b want=0", locked_a); end
      checks++; if ({rise_a, valid_a, timeout_a} !== 3'b000) begin bad++; $display("FAIL rm_pulses got=%b want=000", {rise_a, valid_a, timeout_a}); end
      repeat (2) tick();
      rst_n = 1'b1;
      clear_queues();
      repeat (3) drive_period(5, 4);
      tail();
      checks++; if (vper_a_q.size() !== 2) begin bad++; $display("FAIL rm_valid_count got=%0d want=2", vper_a_q.size()); end
      got  = (vcyc_a_q.size() > 0) ? vcyc_a_q[0] : -1;
      want = (rise_a_q.size() > 1) ? rise_a_q[1] : -2;
      checks++; if (got !== want) begin bad++; $display("FAIL rm_first_valid_cyc got=%0d want=%0d", got, want); end
      got = (vper_a_q.size() > 0) ? vper_a_q[0] : -1;
      checks++; if (got !== 9) begin bad++; $display("FAIL rm_first_period got=%0d want=9", got); end
   endtask

   // Irregular waveform: both instances report the same values, dut_b 2 cycles early.
   task automatic test_sync_offset();
      int got;
      int want_p[3];
      int want_h[3];
      want_p = '{7, 8, 8};
      want_h = '{3, 5, 2};
      do_reset();
      drive_period(2, 3);
      drive_period(4, 5);
      drive_period(3, 2);
      drive_period(6, 6);
      tail();
      checks++; if (rise_a_q.size() !== 4) begin bad++; $display("FAIL so_rise_count_a got=%0d want=4", rise_a_q.size()); end
      checks++; if (rise_b_q.size() !== 4) begin bad++; $display("FAIL so_rise_count_b got=%0d want=4", rise_b_q.size()); end
      for (int k = 0; k < 4; k++) begin
         got = ((k < rise_a_q.size()) && (k < rise_b_q.size())) ? (rise_a_q[k] - rise_b_q[k]) : -1;
         checks++; if (got !== 2) begin bad++; $display("FAIL so_rise_offset[%0d] got=%0d want=2", k, got); end
      end
      for (int k = 0; k < 3; k++) begin
         got = (k < vper_a_q.size()) ? vper_a_q[k] : -1;
         checks++; if (got !== want_p[k]) begin bad++; $display("FAIL so_period_a[%0d] got=%0d want=%0d", k, got, want_p[k]); end
         got = (k < vhigh_a_q.size()) ? vhigh_a_q[k] : -1;
         checks++; if (got !== want_h[k]) begin bad++; $display("FAIL so_high_a[%0d] got=%0d want=%0d", k, got, want_h[k]); end
         got = (k < vper_b_q.size()) ? vper_b_q[k] : -1;
         checks++; if (got !== want_p[k]) begin bad++; $display("FAIL so_period_b[%0d] got=%0d want=%0d", k, got, want_p[k]); end
         got = (k < vhigh_b_q.size()) ? vhigh_b_q[k] : -1;
         checks++; if (got !== want_h[k]) begin bad++; $display("FAIL so_high_b[%0d] got=%0d want=%0d", k, got, want_h[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_div6();
      test_div5_to_7();
      test_timeout();
      test_boundary31();
      test_reset_mid();
      test_sync_offset();
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
